// File: rtl/fsm_seq_param.sv
// Parametrised one-hot Moore sequencer: IDLE plus NUM_STAGES stages, each with a dwell timeout.
// Optional macro FSM_SEQ_ONEHOT_CHECK_EN adds an err pulse when an illegal (non one-hot) state is recovered.
module fsm_seq_param #(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT = 15,
  parameter logic [NUM_STAGES-1:0] AUTO_MASK = {{(NUM_STAGES-1){1'b0}}, 1'b1},
  parameter int TMR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] adv,
  output logic [NUM_STAGES-1:0] out_therm,
  output logic [NUM_STAGES:0]   state_o,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SW = NUM_STAGES + 1;
  localparam logic [SW-1:0] IDLE_OH = {{NUM_STAGES{1'b0}}, 1'b1};
  // With the timeout disabled the timer still saturates, at its all-ones value.
  localparam logic [TMR_W-1:0] TMR_LIMIT = (TIMEOUT == 0) ? {TMR_W{1'b1}} : TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_STAGE,
    PH_ILLEGAL
  } phase_e;

  phase_e              phase;
  logic [SW-1:0]       state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [NUM_STAGES-1:0] out_therm_q, out_therm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  function automatic logic [SW-1:0] stage_oh(input int k);
    return SW'(1) << k;
  endfunction

  always_comb begin
    state_d = IDLE_OH;
    timer_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    phase   = PH_ILLEGAL;
    if (state_q == IDLE_OH) phase = PH_IDLE;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if (state_q == stage_oh(k)) phase = PH_STAGE;
    end

    case (phase)
      PH_IDLE: begin
        if (start && !abort) state_d = stage_oh(1);
      end
      PH_STAGE: begin
        for (int k = 1; k <= NUM_STAGES; k++) begin
          if (state_q == stage_oh(k)) begin
            if (abort) begin
              state_d = IDLE_OH;
            end else if (AUTO_MASK[k-1] || adv[k-1]) begin
              if (k == NUM_STAGES) begin
                state_d = IDLE_OH;
                done_d  = 1'b1;
              end else begin
                state_d = stage_oh(k + 1);
              end
            end else if ((TIMEOUT != 0) && (timer_q == TMR_LIMIT)) begin
              state_d = IDLE_OH;
              err_d   = 1'b1;
            end else begin
              state_d = state_q;
              timer_d = (timer_q == TMR_LIMIT) ? timer_q : timer_q + 1'b1;
            end
          end
        end
      end
      default: begin
`ifdef FSM_SEQ_ONEHOT_CHECK_EN
        err_d = 1'b1;
`else
        err_d = 1'b0;
`endif
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_o.
  always_comb begin
    out_therm_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      out_therm_d[i] = |(state_d >> (i + 1));
    end
    busy_d = ~state_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_OH;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_therm_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_therm_q <= out_therm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign state_o   = state_q;
  assign out_therm = out_therm_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
